bcd_digit_encoder: RTL and testbench
====================================

// Module: bcd_digit_encoder
// PURPOSE
// - Source side of the seven-segment digit interface: turns a binary value (score, counter) into per-digit 4-bit codes
//   that feed the seven-segment renderer's num input, one nibble per rendered digit.
// - Iterative double-dabble conversion, one bit per clock, with start/busy/done handshake; outputs held stable between conversions.
// - Optional leading-zero blanking: blanked digits carry BLANK_DIGIT (4'hF), which the renderer draws with all segments off.
// PARAMETERS
// - BIN_W    10  width of binary input
// - DIGITS   4   number of BCD digits produced; elaboration-time assertion: 10**DIGITS > 2**BIN_W - 1
// - BLANK_LZ 1   1: leading zero digits output BLANK_DIGIT; 0: output 4'd0
// PORTS
// - clk      in   1             system clock; all logic rising-edge
// - rst      in   1             synchronous, active-high reset
// - start    in   1             request conversion of bin; sampled only when accepting (see BEHAVIOUR)
// - bin      in   BIN_W         binary value, captured on the accepted start cycle
// - busy     out  1             1 while conversion in progress (SHIFT state)
// - done     out  1             1-cycle pulse: digits just updated
// - digits   out  DIGITS*4      digit k at [4k+3:4k], k=0 is least significant; drives renderer num inputs
// BEHAVIOUR
// - Reset (rst=1 at clk edge): state=IDLE, busy=0, done=0, scratch cleared; digits show "0":
//   digit0=4'd0, digits 1..DIGITS-1 = BLANK_DIGIT if BLANK_LZ else 4'd0. Reset wins over every other input.
// - States: IDLE -> SHIFT -> DONE -> IDLE.
//   IDLE: start=1 -> capture bin into shift reg, clear BCD scratch, bit counter=BIN_W-1, go SHIFT.
//   SHIFT: per cycle, each BCD nibble >=5 gets +3 (all nibbles in parallel, from registered value), then whole
//     {bcd, bin_sr} shifts left 1 (bin MSB enters bcd bit 0). Counter decrements; after the cycle with counter=0 go DONE.
//   DONE: digits register loads converted BCD (blanking applied), done=1 this cycle only; start=1 here is accepted
//     exactly as in IDLE (back-to-back), else go IDLE.
// - start while in SHIFT ignored (no queuing); bin changes after capture ignored.
// - Latency: start accepted at edge N -> SHIFT occupies edges N+1..N+BIN_W -> done=1 and new digits visible in the
//   cycle after edge N+BIN_W+1. Back-to-back throughput: one conversion per BIN_W+1 cycles.
// - digits change only in DONE; stable in IDLE/SHIFT (renderer never sees partial results).
// - Blanking: scan from digit DIGITS-1 down; digits that are 0 and above the most significant nonzero digit -> BLANK_DIGIT.
//   Digit0 is never blanked (value 0 renders "0").
// - Widths: scratch = DIGITS*4 + BIN_W bits; add-3 per nibble is 4-bit, no carry out (nibble <=9 before correction).
// - rst during SHIFT: conversion abandoned, no done pulse, digits forced to reset value.
// STRUCTURE
// - Shared package (display_pkg): BLANK_DIGIT = 4'hF, DIGIT_W = 4, enum enc_state_t {IDLE, SHIFT, DONE}.
// - Sub-module bcd_add3: combinational 4-bit nibble corrector (in>=5 ? in+3 : in), generate-instantiated DIGITS times.
// - Top holds FSM, bit counter ($clog2(BIN_W) bits), scratch shift reg, output digit reg and blanking logic.
// TESTING
// - Reset: assert rst 2 cycles -> busy=0, done=0, digits=16'hFFF0 (BLANK_LZ=1), 16'h0000 (BLANK_LZ=0 build).
// - bin=0, start 1 cycle -> done pulse exactly BIN_W+1 cycles later (11), digits=16'hFFF0.
// - bin=7 -> 16'hFFF7; bin=40 -> 16'hFF40; bin=1023 -> 16'h1023; bin=1000 -> 16'h1000 (inner zeros not blanked).
// - Back-to-back: start held high, bin=123 then 456 -> done pulses 11 cycles apart, digits 16'hF123 then 16'hF456.
// - start pulse with bin=999 during SHIFT of bin=5 -> ignored: one done, digits=16'hFFF5, busy never re-extends.
// - rst pulsed mid-SHIFT of bin=512 -> no done pulse, digits return to reset value, next start converts normally.
// - Random sweep 0..1023 vs. reference model: each done yields correct BCD; digits stable between done pulses.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and constants for the seven-segment digit path.
// Digit code width, the blank-digit code and the encoder state enum.
package display_pkg;

  localparam int DIGIT_W = 4;

  // Renderer draws this code with every segment off.
  localparam logic [DIGIT_W-1:0] BLANK_DIGIT = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } enc_state_t;

endpackage

// File: rtl/bcd_digit_encoder_if.sv
// Handshake and result bundle between a value source and the BCD digit encoder.
// master drives start/bin; slave returns busy/done/digits.
interface bcd_digit_encoder_if #(
  parameter int BIN_W  = 10,
  parameter int DIGITS = 4
);
  import display_pkg::*;

  logic                        start;
  logic [BIN_W-1:0]            bin;
  logic                        busy;
  logic                        done;
  logic [DIGITS*DIGIT_W-1:0]   digits;

  modport master (
    output start,
    output bin,
    input  busy,
    input  done,
    input  digits
  );

  modport slave (
    input  start,
    input  bin,
    output busy,
    output done,
    output digits
  );

endinterface

// File: rtl/bcd_add3.sv
// Double-dabble nibble corrector: adds 3 to a BCD nibble of 5 or more.
// Purely combinational; input is at most 9 so the 4-bit sum never overflows.
module bcd_add3
  import display_pkg::*;
(
  input  logic [DIGIT_W-1:0] din,
  output logic [DIGIT_W-1:0] dout
);

  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bcd_digit_encoder.sv
// Binary to per-digit BCD codes by double-dabble, one input bit per clock, with leading-zero blanking.
// Done and new digits appear BIN_W+1 cycles after an accepted start; start is ignored while busy.
module bcd_digit_encoder
  import display_pkg::*;
#(
  parameter int BIN_W    = 10,
  parameter int DIGITS   = 4,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  bcd_digit_encoder_if.slave   enc
);

  localparam int BCD_W = DIGITS * DIGIT_W;
  localparam int SCR_W = BCD_W + BIN_W;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  // DIGITS decimal digits must be able to hold the largest BIN_W-bit value.
  generate
    if (!((64'd10 ** DIGITS) > ((64'd1 << BIN_W) - 64'd1))) begin : g_range_chk
      $error("bcd_digit_encoder: DIGITS too small for BIN_W");
    end
  endgenerate

  enc_state_t        state_q;
  enc_state_t        state_d;
  logic              load;
  logic              shift;
  logic              commit;

  logic [CNT_W-1:0]  cnt_q;
  logic [SCR_W-1:0]  scr_q;
  logic [BCD_W-1:0]  bcd_adj;
  logic [BCD_W-1:0]  bcd_blank;
  logic [BCD_W-1:0]  digits_rst;
  logic [BCD_W-1:0]  digits_q;
  logic              done_q;
  logic              lead;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    shift   = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (enc.start) begin
          load    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shift = 1'b1;
        if (cnt_q == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        commit = 1'b1;
        if (enc.start) begin
          load    = 1'b1;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // All nibble corrections look at the registered scratch, then the whole word shifts.
  generate
    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
      bcd_add3 u_add3 (
        .din  (scr_q[BIN_W + g*DIGIT_W +: DIGIT_W]),
        .dout (bcd_adj[g*DIGIT_W +: DIGIT_W])
      );
    end
  endgenerate

  always_comb begin
    digits_rst = '0;
    for (int k = 1; k < DIGITS; k++) begin
      if (BLANK_LZ) begin
        digits_rst[k*DIGIT_W +: DIGIT_W] = BLANK_DIGIT;
      end
    end
  end

  // Scan from the top digit down; zeros above the first nonzero digit are blanked, digit 0 never.
  always_comb begin
    bcd_blank = scr_q[SCR_W-1 -: BCD_W];
    lead      = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      if (scr_q[BIN_W + k*DIGIT_W +: DIGIT_W] != '0) begin
        lead = 1'b0;
      end
      if (lead && BLANK_LZ) begin
        bcd_blank[k*DIGIT_W +: DIGIT_W] = BLANK_DIGIT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      scr_q    <= '0;
      digits_q <= digits_rst;
      done_q   <= 1'b0;
    end else begin
      done_q <= commit;
      if (load) begin
        scr_q <= {{BCD_W{1'b0}}, enc.bin};
        cnt_q <= CNT_LAST;
      end else if (shift) begin
        scr_q <= {bcd_adj, scr_q[BIN_W-1:0]} << 1;
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (commit) begin
        digits_q <= bcd_blank;
      end
    end
  end

  assign enc.busy   = (state_q == SHIFT);
  assign enc.done   = done_q;
  assign enc.digits = digits_q;

endmodule

// File: tb/tb_bcd_digit_encoder.sv
// Bench for bcd_digit_encoder: directed cases plus a random sweep against a decimal reference model.
// Runs a blanking and a non-blanking instance side by side on the same stimulus.
module tb_bcd_digit_encoder;
  import display_pkg::*;

  localparam int BIN_W  = 10;
  localparam int DIGITS = 4;
  localparam int BCD_W  = DIGITS * DIGIT_W;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  int unstable = 0;
  logic [BCD_W-1:0] prev_dig;

  bcd_digit_encoder_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) enc_if ();
  bcd_digit_encoder_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) enc0_if ();

  bcd_digit_encoder #(.BIN_W(BIN_W), .DIGITS(DIGITS), .BLANK_LZ(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .enc (enc_if)
  );

  bcd_digit_encoder #(.BIN_W(BIN_W), .DIGITS(DIGITS), .BLANK_LZ(1'b0)) dut0 (
    .clk (clk),
    .rst (rst),
    .enc (enc0_if)
  );

  assign enc0_if.start = enc_if.start;
  assign enc0_if.bin   = enc_if.bin;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Decimal digits by division; digit k>0 is blank exactly when the value is below 10**k.
  function automatic logic [BCD_W-1:0] ref_digits(input int v, input bit blank);
    logic [BCD_W-1:0] r;
    int p;
    r = '0;
    p = 1;
    for (int k = 0; k < DIGITS; k++) begin
      if (blank && k > 0 && v < p) r[k*DIGIT_W +: DIGIT_W] = BLANK_DIGIT;
      else                         r[k*DIGIT_W +: DIGIT_W] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Digits may only move on a done cycle or because of reset.
  initial begin
    bit r;
    prev_dig = enc_if.digits;
    forever begin
      @(posedge clk);
      r = rst;
      @(negedge clk);
      if (enc_if.done) done_cnt++;
      else if (!r && enc_if.digits !== prev_dig) unstable++;
      prev_dig = enc_if.digits;
    end
  end

  // Start a conversion of v; optionally poke a stray start (bin=999) poke cycles into SHIFT.
  task automatic convert(input int v, input string tag, input int poke);
    int cyc;
    int busy_n;
    bit got;
    enc_if.start = 1'b1;
    enc_if.bin   = BIN_W'(v);
    step();
    enc_if.start = 1'b0;
    enc_if.bin   = BIN_W'($urandom_range(0, 1023));
    chk({tag, "_busy"}, 64'(enc_if.busy), 64'h1);
    cyc    = 0;
    busy_n = 1;
    got    = 1'b0;
    while (!got && cyc < 40) begin
      enc_if.start = (cyc == poke);
      if (cyc == poke) enc_if.bin = BIN_W'(999);
      step();
      cyc++;
      if (enc_if.busy) busy_n++;
      if (enc_if.done) got = 1'b1;
    end
    enc_if.start = 1'b0;
    chk({tag, "_lat"}, 64'(cyc), 64'(BIN_W + 1));
    chk({tag, "_busycyc"}, 64'(busy_n), 64'(BIN_W));
    chk({tag, "_dig"}, 64'(enc_if.digits), 64'(ref_digits(v, 1'b1)));
    chk({tag, "_dig0"}, 64'(enc0_if.digits), 64'(ref_digits(v, 1'b0)));
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    step();
    cyc++;
    while (!enc_if.done && cyc < 40) begin
      step();
      cyc++;
    end
  endtask

  initial begin
    int v;
    int cyc;
    int dc0;

    enc_if.start = 1'b0;
    enc_if.bin   = '0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_busy", 64'(enc_if.busy), 64'h0);
    chk("rst_done", 64'(enc_if.done), 64'h0);
    chk("rst_dig", 64'(enc_if.digits), 64'hFFF0);
    chk("rst_dig0", 64'(enc0_if.digits), 64'h0000);

    convert(0, "zero", -1);
    chk("zero_val", 64'(enc_if.digits), 64'hFFF0);
    convert(7, "seven", -1);
    chk("seven_val", 64'(enc_if.digits), 64'hFFF7);
    convert(40, "forty", -1);
    chk("forty_val", 64'(enc_if.digits), 64'hFF40);
    chk("forty_val0", 64'(enc0_if.digits), 64'h0040);
    convert(1023, "max", -1);
    chk("max_val", 64'(enc_if.digits), 64'h1023);
    convert(1000, "k", -1);
    chk("k_val", 64'(enc_if.digits), 64'h1000);

    // Back-to-back: start held high, bin changed right after the first capture.
    step();
    dc0 = done_cnt;
    enc_if.start = 1'b1;
    enc_if.bin   = BIN_W'(123);
    step();
    enc_if.bin   = BIN_W'(456);
    wait_done(cyc);
    chk("b2b_lat1", 64'(cyc), 64'(BIN_W + 1));
    chk("b2b_dig1", 64'(enc_if.digits), 64'hF123);
    enc_if.start = 1'b0;
    wait_done(cyc);
    chk("b2b_gap", 64'(cyc), 64'(BIN_W + 1));
    chk("b2b_dig2", 64'(enc_if.digits), 64'hF456);
    repeat (15) step();
    chk("b2b_idle", 64'(enc_if.busy), 64'h0);
    chk("b2b_ndone", 64'(done_cnt - dc0), 64'd2);

    // Stray start during SHIFT must be dropped.
    dc0 = done_cnt;
    convert(5, "ign", 3);
    repeat (15) step();
    chk("ign_val", 64'(enc_if.digits), 64'hFFF5);
    chk("ign_ndone", 64'(done_cnt - dc0), 64'd1);
    chk("ign_idle", 64'(enc_if.busy), 64'h0);

    // Reset in the middle of a conversion.
    enc_if.start = 1'b1;
    enc_if.bin   = BIN_W'(512);
    step();
    enc_if.start = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_busy", 64'(enc_if.busy), 64'h0);
    chk("mrst_done", 64'(enc_if.done), 64'h0);
    chk("mrst_dig", 64'(enc_if.digits), 64'hFFF0);
    chk("mrst_dig0", 64'(enc0_if.digits), 64'h0000);
    dc0 = done_cnt;
    repeat (20) step();
    chk("mrst_ndone", 64'(done_cnt - dc0), 64'd0);
    convert(512, "post", -1);
    chk("post_val", 64'(enc_if.digits), 64'hF512);

    for (int i = 0; i < 40; i++) begin
      v = int'($urandom_range(0, 1023));
      repeat ($urandom_range(0, 3)) step();
      convert(v, "rand", -1);
    end

    repeat (3) step();
    chk("stable", 64'(unstable), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
